// File: rtl/arbiter_wrr_handshake.sv
// Weighted round-robin arbiter with a registered one-hot grant held until gnt_ack.
// A winner may keep the grant for up to its weight of back-to-back transactions.
module arbiter_wrr_handshake #(
    parameter int N   = 4,
    parameter int WW  = 4,
    parameter int IDW = (N > 1) ? $clog2(N) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    req,
    input  logic [N*WW-1:0] cfg_weight,
    input  logic            block_arb,
    input  logic            gnt_ack,
    output logic [N-1:0]    grant,
    output logic            grant_valid,
    output logic [IDW-1:0]  grant_id,
    output logic [WW-1:0]   credit_left
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t         state, state_n;
    logic [IDW-1:0] ptr, ptr_n;
    logic [N-1:0]   grant_n;
    logic [IDW-1:0] id_n;
    logic [WW-1:0]  credit_n;
    logic           launch;
    logic           keep;
    logic [IDW-1:0] start;
    logic [IDW:0]   win;

    // Returns {found, index} of the first set bit at or after start, wrapping.
    function automatic logic [IDW:0] pick(input logic [N-1:0] r, input logic [IDW-1:0] s);
        logic [IDW:0] res;
        int           j;
        res = '0;
        for (int i = N - 1; i >= 0; i--) begin
            j = int'(s) + i;
            if (j >= N) j = j - N;
            if (r[j]) res = {1'b1, IDW'(j)};
        end
        return res;
    endfunction

    function automatic logic [WW-1:0] quantum(input logic [WW-1:0] w);
        return (w == '0) ? WW'(1) : w;
    endfunction

    function automatic logic [IDW-1:0] next_idx(input logic [IDW-1:0] w);
        return (w == IDW'(N - 1)) ? '0 : w + IDW'(1);
    endfunction

    always_comb begin
        state_n  = state;
        ptr_n    = ptr;
        grant_n  = grant;
        id_n     = grant_id;
        credit_n = credit_left;
        launch   = 1'b0;
        keep     = 1'b0;
        start    = ptr;
        win      = '0;

        case (state)
            IDLE: begin
                if ((|req) && !block_arb) launch = 1'b1;
            end
            BUSY: begin
                if (gnt_ack) begin
                    keep = (credit_left > WW'(1)) && req[grant_id];
                    if (keep && !block_arb) begin
                        credit_n = credit_left - WW'(1);
                    end else begin
                        // A quantum cut short by block_arb leaves the pointer where it was.
                        if (!keep) ptr_n = next_idx(grant_id);
                        start = ptr_n;
                        if (!keep && (|req) && !block_arb) begin
                            launch = 1'b1;
                        end else begin
                            state_n  = IDLE;
                            grant_n  = '0;
                            id_n     = '0;
                            credit_n = '0;
                        end
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        if (launch) begin
            win      = pick(req, start);
            id_n     = win[IDW-1:0];
            grant_n  = N'(1) << id_n;
            credit_n = quantum(cfg_weight[int'(id_n)*WW +: WW]);
            state_n  = BUSY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ptr         <= '0;
            grant       <= '0;
            grant_id    <= '0;
            credit_left <= '0;
        end else begin
            state       <= state_n;
            ptr         <= ptr_n;
            grant       <= grant_n;
            grant_id    <= id_n;
            credit_left <= credit_n;
        end
    end

    assign grant_valid = |grant;

endmodule

// File: tb/tb_arbiter_wrr_handshake.sv
// Directed bench for arbiter_wrr_handshake: expected acked transactions are queued
// by the stimulus and popped by an independent monitor on each acked grant.
module tb_arbiter_wrr_handshake;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [15:0] cfg_weight;
    logic        block_arb;
    logic        gnt_ack;
    logic [3:0]  grant;
    logic        grant_valid;
    logic [1:0]  grant_id;
    logic [3:0]  credit_left;

    typedef struct packed {
        logic [3:0] g;
        logic [1:0] id;
        logic [3:0] cr;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    arbiter_wrr_handshake #(.N(4), .WW(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .cfg_weight  (cfg_weight),
        .block_arb   (block_arb),
        .gnt_ack     (gnt_ack),
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_id    (grant_id),
        .credit_left (credit_left)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] g, input logic [1:0] id, input logic [3:0] cr);
        exp_t e;
        e.g  = g;
        e.id = id;
        e.cr = cr;
        q.push_back(e);
    endtask

    task automatic expect_idle(input string name);
        @(negedge clk);
        chk({name, "_grant"}, {28'd0, grant}, 32'd0);
        chk({name, "_valid"}, {31'd0, grant_valid}, 32'd0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n     = 1'b0;
        req       = '0;
        gnt_ack   = 1'b0;
        block_arb = 1'b0;
        @(negedge clk);
        chk("rst_grant",  {28'd0, grant},       32'd0);
        chk("rst_valid",  {31'd0, grant_valid}, 32'd0);
        chk("rst_id",     {30'd0, grant_id},    32'd0);
        chk("rst_credit", {28'd0, credit_left}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Monitor: structural invariants every cycle, plus one scoreboard pop per acked grant.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            checks++;
            if ($countones(grant) > 1 || grant_valid !== (|grant) ||
                (grant == 4'd0 && grant_id != 2'd0) ||
                (grant != 4'd0 && grant[grant_id] !== 1'b1)) begin
                failures++;
                $display("FAIL invariant grant=%b valid=%b id=%0d t=%0t",
                         grant, grant_valid, grant_id, $time);
            end
            if (grant_valid && gnt_ack) begin
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_txn grant=%b id=%0d credit=%0d t=%0t",
                             grant, grant_id, credit_left, $time);
                end else begin
                    e = q.pop_front();
                    if ({grant, grant_id, credit_left} !== {e.g, e.id, e.cr}) begin
                        failures++;
                        $display("FAIL txn got grant=%b id=%0d credit=%0d expected grant=%b id=%0d credit=%0d t=%0t",
                                 grant, grant_id, credit_left, e.g, e.id, e.cr, $time);
                    end
                end
            end
        end
    end

    initial begin
        rst_n      = 1'b0;
        req        = '0;
        cfg_weight = 16'h1111;
        block_arb  = 1'b0;
        gnt_ack    = 1'b0;

        // Test 1: plain round robin between clients 0 and 2, no bubbles.
        do_reset();
        cfg_weight = 16'h1111;
        push(4'b0001, 2'd0, 4'd1);
        push(4'b0100, 2'd2, 4'd1);
        push(4'b0001, 2'd0, 4'd1);
        req = 4'b0101;
        cyc();
        gnt_ack = 1'b1;
        cyc();
        cyc();
        req = 4'b0000;
        cyc();
        gnt_ack = 1'b0;
        expect_idle("t1_end");

        // Test 2: weight 3 vs weight 1 with ack every cycle.
        do_reset();
        cfg_weight = 16'h1113;
        push(4'b0001, 2'd0, 4'd3);
        push(4'b0001, 2'd0, 4'd2);
        push(4'b0001, 2'd0, 4'd1);
        push(4'b0010, 2'd1, 4'd1);
        push(4'b0001, 2'd0, 4'd3);
        req = 4'b0011;
        cyc();
        gnt_ack = 1'b1;
        cyc();
        cyc();
        cyc();
        cyc();
        req = 4'b0000;
        cyc();
        gnt_ack = 1'b0;
        expect_idle("t2_end");

        // Test 3: zero weight behaves as one.
        do_reset();
        cfg_weight = 16'h1110;
        push(4'b0001, 2'd0, 4'd1);
        push(4'b0001, 2'd0, 4'd1);
        push(4'b0001, 2'd0, 4'd1);
        req = 4'b0001;
        cyc();
        gnt_ack = 1'b1;
        cyc();
        cyc();
        req = 4'b0000;
        cyc();
        gnt_ack = 1'b0;
        expect_idle("t3_end");

        // Test 4: grant is sticky after its requester drops req.
        do_reset();
        cfg_weight = 16'h1111;
        push(4'b0010, 2'd1, 4'd1);
        push(4'b0100, 2'd2, 4'd1);
        req = 4'b0010;
        cyc();
        req = 4'b0100;
        cyc();
        @(negedge clk);
        chk("t4_sticky", {28'd0, grant}, 32'h2);
        cyc();
        gnt_ack = 1'b1;
        cyc();
        req = 4'b0000;
        cyc();
        gnt_ack = 1'b0;
        expect_idle("t4_end");

        // Test 5: block_arb cuts a weight-2 quantum short without moving the pointer.
        do_reset();
        cfg_weight = 16'h1211;
        push(4'b0010, 2'd1, 4'd1);
        push(4'b0100, 2'd2, 4'd2);
        push(4'b0100, 2'd2, 4'd2);
        req = 4'b0110;
        cyc();
        gnt_ack = 1'b1;
        cyc();
        gnt_ack   = 1'b0;
        block_arb = 1'b1;
        cyc();
        @(negedge clk);
        chk("t5_held", {28'd0, grant}, 32'h4);
        cyc();
        gnt_ack = 1'b1;
        cyc();
        gnt_ack = 1'b0;
        req     = 4'b1111;
        expect_idle("t5_blocked");
        cyc();
        expect_idle("t5_still_blocked");
        cyc();
        block_arb = 1'b0;
        cyc();
        gnt_ack = 1'b1;
        req     = 4'b0000;
        cyc();
        gnt_ack = 1'b0;
        expect_idle("t5_end");

        // Test 6: asynchronous reset mid-grant, then a fresh quantum.
        do_reset();
        cfg_weight = 16'h5111;
        req = 4'b1000;
        cyc();
        @(negedge clk);
        chk("t6_grant",  {28'd0, grant},       32'h8);
        chk("t6_credit", {28'd0, credit_left}, 32'h5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_grant",  {28'd0, grant},       32'd0);
        chk("t6_async_valid",  {31'd0, grant_valid}, 32'd0);
        chk("t6_async_id",     {30'd0, grant_id},    32'd0);
        chk("t6_async_credit", {28'd0, credit_left}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        push(4'b1000, 2'd3, 4'd5);
        cyc();
        gnt_ack = 1'b1;
        req     = 4'b0000;
        cyc();
        gnt_ack = 1'b0;
        expect_idle("t6_end");

        @(negedge clk);
        chk("queue_drained", q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
